pipe_step_ctrl: RTL and testbench
=================================

Name: pipe_step_ctrl

Overview:
- Run controller for the five-stage pipeline (Fetch, Decode, Execute, Memory, Writeback).
- Replaces the free-running divided clock. All stages run on the PLL clock and advance only on this block's O_STEP_EN pulse.
- Sequences power-up after PLL lock, and provides run, halt, single-step and PC-breakpoint control.
- O_LOCK drives the Fetch I_LOCK chain.

Parameters:
DIV_WIDTH, 32, width of divide ratio and step counter
LOCK_SETTLE, 16, cycles to wait after PLL lock before releasing O_LOCK (must be >=1)
PC_WIDTH, 16, PC width (matches `PC_WIDTH)

Ports:
I_CLOCK  in  1  PLL output clock
I_RESET_N  in  1  reset
I_PLL_LOCKED  in  1  PLL locked indicator
I_DIV  in  DIV_WIDTH  clock cycles per pipeline step in RUN; 0 treated as 1
I_RUN  in  1  run request (level; rising edge starts a run)
I_HALT_REQ  in  1  halt request (level)
I_STEP  in  1  single-step request (rising edge)
I_BP_ENABLE  in  1  breakpoint enable
I_BP_PC  in  PC_WIDTH  breakpoint address
I_PC  in  PC_WIDTH  current Fetch PC
O_LOCK  out  1  pipeline enable/lock to Fetch
O_STEP_EN  out  1  one-cycle pipeline advance pulse
O_STATE  out  3  current state encoding
O_BP_HIT  out  1  high while in BREAK
O_STEP_COUNT  out  DIV_WIDTH  number of O_STEP_EN pulses issued

Behaviour:
- Clock and reset: single clock I_CLOCK. I_RESET_N is asynchronous, active-low.
- Reset values: state WAIT_LOCK, O_LOCK=0, O_STEP_EN=0, O_BP_HIT=0, O_STEP_COUNT=0. Divider counter, settle counter and edge-detect registers all 0.
- Outputs: all registered. Inputs are synchronous to I_CLOCK.
- Edge detection: I_RUN and I_STEP rising edges come from a one-register delay (sampled high now, low last cycle).
- State encoding: WAIT_LOCK=0, SETTLE=1, HALTED=2, RUN=3, STEP=4, BREAK=5. Codes 6 and 7 go to WAIT_LOCK.
- Priority (highest first):
  - I_PLL_LOCKED=0 in any state: next state WAIT_LOCK, O_LOCK=0, no pulse that cycle.
  - Then state-specific rules below.
- WAIT_LOCK: when I_PLL_LOCKED=1, go to SETTLE and load settle counter with LOCK_SETTLE-1.
- SETTLE:
  - Decrement each cycle.
  - At 0: O_LOCK<=1; go to RUN if I_RUN=1 and I_HALT_REQ=0, else HALTED.
  - Divider counter cleared on exit.
- HALTED:
  - I_STEP edge goes to STEP. Step wins over a simultaneous run edge.
  - Otherwise, I_RUN edge with I_HALT_REQ=0 goes to RUN, clearing the divider counter.
  - A level-high I_RUN without an edge does not restart.
- STEP: O_STEP_EN<=1 for exactly one cycle, then HALTED. The breakpoint is not checked.
- RUN divider:
  - eff_div = max(I_DIV,1), sampled every cycle.
  - Counter increments each cycle.
  - When counter >= eff_div-1: clear counter and issue pulse. This covers I_DIV shrinking mid-count.
  - First pulse: O_STEP_EN high in the eff_div-th cycle after entering RUN. Pulse period is eff_div cycles; eff_div=1 gives O_STEP_EN continuously high.
- RUN breakpoint: at a pulse point with I_BP_ENABLE=1, I_PC==I_BP_PC and skip_bp=0, suppress the pulse and go to BREAK.
- RUN exit: I_HALT_REQ=1 or I_RUN=0 goes to HALTED with no pulse that cycle. Halt beats a same-cycle pulse and breakpoint.
- skip_bp flag:
  - Set on BREAK exit.
  - Cleared after the next issued pulse.
  - Guarantees forward progress past a breakpoint.
- BREAK:
  - O_BP_HIT=1.
  - I_STEP edge goes to STEP, then HALTED.
  - I_RUN edge with I_HALT_REQ=0 goes to RUN.
  - Both exits set skip_bp.
- O_STEP_COUNT: increments on every cycle O_STEP_EN=1. Wraps modulo 2^DIV_WIDTH. Cleared only by reset.
- Reset mid-operation: asynchronous return to reset values, including during STEP. An in-flight pulse is dropped.
- O_LOCK after lock loss: stays 0 until SETTLE completes again.

Test Plan:
1. Reset low, then PLL_LOCKED=1 at cycle 5, RUN=0 -> O_LOCK rises after 16 SETTLE cycles, O_STATE=2, no O_STEP_EN pulses.
2. HALTED, DIV=4, RUN edge -> O_STEP_EN pulses every 4th cycle, first in cycle 4. After 10 pulses O_STEP_COUNT=10. HALT_REQ -> O_STATE=2 next cycle, no further pulses.
3. HALTED, three STEP edges 5 cycles apart -> exactly 3 single-cycle pulses, O_STEP_COUNT=3. STEP and RUN edges in the same cycle -> one pulse, state returns to HALTED.
4. RUN with DIV=2, BP_ENABLE=1, BP_PC=0x0010, I_PC reaching 0x0010 -> pulse suppressed, O_STATE=5, O_BP_HIT=1. STEP edge -> one pulse, O_STATE=2. RUN edge from BREAK with PC still 0x0010 -> first pulse issued.
5. RUN with DIV=0 -> O_STEP_EN high every cycle. Change DIV from 100 to 3 when counter=50 -> pulse next cycle.
6. PLL_LOCKED drops during RUN -> O_LOCK=0 and O_STATE=0 next cycle. Relock -> SETTLE repeats. Async RESET_N low mid-STEP -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipe_step_ctrl.sv
// Run controller for the five-stage pipeline: sequences power-up after PLL lock and
// gates pipeline advance through a single-cycle step enable (run, halt, step, breakpoint).
module pipe_step_ctrl #(
   parameter int DIV_WIDTH   = 32,
   parameter int LOCK_SETTLE = 16,
   parameter int PC_WIDTH    = 16
) (
   input  logic                 I_CLOCK,
   input  logic                 I_RESET_N,
   input  logic                 I_PLL_LOCKED,
   input  logic [DIV_WIDTH-1:0] I_DIV,
   input  logic                 I_RUN,
   input  logic                 I_HALT_REQ,
   input  logic                 I_STEP,
   input  logic                 I_BP_ENABLE,
   input  logic [PC_WIDTH-1:0]  I_BP_PC,
   input  logic [PC_WIDTH-1:0]  I_PC,
   output logic                 O_LOCK,
   output logic                 O_STEP_EN,
   output logic [2:0]           O_STATE,
   output logic                 O_BP_HIT,
   output logic [DIV_WIDTH-1:0] O_STEP_COUNT
);

   localparam int SW = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      SETTLE    = 3'd1,
      HALTED    = 3'd2,
      RUN       = 3'd3,
      STEP      = 3'd4,
      BREAK     = 3'd5
   } state_t;

   state_t               state;
   logic [SW-1:0]        settle_cnt;
   logic [DIV_WIDTH-1:0] div_cnt;
   logic [DIV_WIDTH-1:0] eff_div;
   logic                 run_q;
   logic                 step_q;
   logic                 skip_bp;
   logic                 run_edge;
   logic                 step_edge;
   logic                 div_hit;
   logic                 bp_match;

   assign O_STATE = state;

   always_comb begin
      eff_div   = (I_DIV == '0) ? DIV_WIDTH'(1) : I_DIV;
      run_edge  = I_RUN & ~run_q;
      step_edge = I_STEP & ~step_q;
      // Compare with >= so a divide ratio that shrinks mid-count fires immediately
      div_hit   = (div_cnt >= (eff_div - DIV_WIDTH'(1)));
      bp_match  = I_BP_ENABLE & (I_PC == I_BP_PC) & ~skip_bp;
   end

   always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         state        <= WAIT_LOCK;
         settle_cnt   <= '0;
         div_cnt      <= '0;
         run_q        <= 1'b0;
         step_q       <= 1'b0;
         skip_bp      <= 1'b0;
         O_LOCK       <= 1'b0;
         O_STEP_EN    <= 1'b0;
         O_BP_HIT     <= 1'b0;
         O_STEP_COUNT <= '0;
      end else begin
         run_q     <= I_RUN;
         step_q    <= I_STEP;
         O_STEP_EN <= 1'b0;
         O_BP_HIT  <= 1'b0;
         if (O_STEP_EN) begin
            O_STEP_COUNT <= O_STEP_COUNT + DIV_WIDTH'(1);
         end

         if (!I_PLL_LOCKED) begin
            state   <= WAIT_LOCK;
            O_LOCK  <= 1'b0;
            skip_bp <= 1'b0;
         end else begin
            case (state)
               WAIT_LOCK: begin
                  state      <= SETTLE;
                  settle_cnt <= SW'(LOCK_SETTLE - 1);
               end
               SETTLE: begin
                  if (settle_cnt == '0) begin
                     O_LOCK  <= 1'b1;
                     div_cnt <= '0;
                     state   <= (I_RUN && !I_HALT_REQ) ? RUN : HALTED;
                  end else begin
                     settle_cnt <= settle_cnt - SW'(1);
                  end
               end
               HALTED: begin
                  if (step_edge) begin
                     state     <= STEP;
                     O_STEP_EN <= 1'b1;
                     skip_bp   <= 1'b0;
                  end else if (run_edge && !I_HALT_REQ) begin
                     state   <= RUN;
                     div_cnt <= '0;
                  end
               end
               RUN: begin
                  // Halt and run-drop take precedence over a pulse or breakpoint due this cycle
                  if (I_HALT_REQ || !I_RUN) begin
                     state <= HALTED;
                  end else if (div_hit) begin
                     div_cnt <= '0;
                     if (bp_match) begin
                        state    <= BREAK;
                        O_BP_HIT <= 1'b1;
                     end else begin
                        O_STEP_EN <= 1'b1;
                        skip_bp   <= 1'b0;
                     end
                  end else begin
                     div_cnt <= div_cnt + DIV_WIDTH'(1);
                  end
               end
               STEP: begin
                  state <= HALTED;
               end
               BREAK: begin
                  // Leaving a breakpoint arms skip_bp so the same PC cannot re-trap immediately
                  if (step_edge) begin
                     state     <= STEP;
                     O_STEP_EN <= 1'b1;
                     skip_bp   <= 1'b1;
                  end else if (run_edge && !I_HALT_REQ) begin
                     state   <= RUN;
                     div_cnt <= '0;
                     skip_bp <= 1'b1;
                  end else begin
                     O_BP_HIT <= 1'b1;
                  end
               end
               default: begin
                  state <= WAIT_LOCK;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Directed bench for pipe_step_ctrl: a cycle-level behavioural model is compared every
// cycle, and literal expectations pin the key points of each scenario.
module tb_pipe_step_ctrl;

   localparam int DW = 32;
   localparam int LS = 16;
   localparam int PW = 16;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          locked = 1'b0;
   logic          run    = 1'b0;
   logic          halt   = 1'b0;
   logic          step   = 1'b0;
   logic          bp_en  = 1'b0;
   logic [DW-1:0] div    = 32'd4;
   logic [PW-1:0] bp_pc  = '0;
   logic [PW-1:0] pc     = '0;

   logic          lock;
   logic          step_en;
   logic [2:0]    state;
   logic          bp_hit;
   logic [DW-1:0] count;

   int errors = 0;
   int checks = 0;

   pipe_step_ctrl #(.DIV_WIDTH(DW), .LOCK_SETTLE(LS), .PC_WIDTH(PW)) dut (
      .I_CLOCK     (clk),
      .I_RESET_N   (rst_n),
      .I_PLL_LOCKED(locked),
      .I_DIV       (div),
      .I_RUN       (run),
      .I_HALT_REQ  (halt),
      .I_STEP      (step),
      .I_BP_ENABLE (bp_en),
      .I_BP_PC     (bp_pc),
      .I_PC        (pc),
      .O_LOCK      (lock),
      .O_STEP_EN   (step_en),
      .O_STATE     (state),
      .O_BP_HIT    (bp_hit),
      .O_STEP_COUNT(count)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Behavioural model: mode number plus cycles-remaining / cycles-elapsed bookkeeping
   int            m_state;
   logic          m_lock, m_pulse, m_hit, m_skip, m_prev_run, m_prev_step;
   logic [DW-1:0] m_count;
   int            m_settle_left;
   longint        m_elapsed;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = 0; m_lock = 0; m_pulse = 0; m_hit = 0; m_skip = 0;
         m_prev_run = 0; m_prev_step = 0; m_count = '0;
         m_settle_left = 0; m_elapsed = 0;
      end else begin
         logic   run_rise, step_rise, pulse_now, hit_now;
         longint eff;
         run_rise  = run && !m_prev_run;
         step_rise = step && !m_prev_step;
         eff       = (div == 0) ? 64'd1 : longint'(div);
         pulse_now = 0;
         hit_now   = 0;
         m_count   = m_count + DW'(m_pulse);
         if (!locked) begin
            m_state = 0; m_lock = 0; m_skip = 0;
         end else begin
            case (m_state)
               0: begin m_state = 1; m_settle_left = LS; end
               1: begin
                  m_settle_left = m_settle_left - 1;
                  if (m_settle_left == 0) begin
                     m_lock = 1; m_elapsed = 0;
                     m_state = (run && !halt) ? 3 : 2;
                  end
               end
               2: begin
                  if (step_rise) begin m_state = 4; pulse_now = 1; m_skip = 0; end
                  else if (run_rise && !halt) begin m_state = 3; m_elapsed = 0; end
               end
               3: begin
                  if (halt || !run) m_state = 2;
                  else begin
                     m_elapsed = m_elapsed + 1;
                     if (m_elapsed >= eff) begin
                        m_elapsed = 0;
                        if (bp_en && pc == bp_pc && !m_skip) begin m_state = 5; hit_now = 1; end
                        else begin pulse_now = 1; m_skip = 0; end
                     end
                  end
               end
               4: m_state = 2;
               5: begin
                  if (step_rise) begin m_state = 4; pulse_now = 1; m_skip = 1; end
                  else if (run_rise && !halt) begin m_state = 3; m_elapsed = 0; m_skip = 1; end
                  else hit_now = 1;
               end
               default: m_state = 0;
            endcase
         end
         m_pulse     = pulse_now;
         m_hit       = hit_now;
         m_prev_run  = run;
         m_prev_step = step;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            check_output("cyc_state",   64'(state),   64'(m_state));
            check_output("cyc_lock",    64'(lock),    64'(m_lock));
            check_output("cyc_step_en", 64'(step_en), 64'(m_pulse));
            check_output("cyc_bp_hit",  64'(bp_hit),  64'(m_hit));
            check_output("cyc_count",   64'(count),   64'(m_count));
         end
      end
   end

   initial begin
      // Reset and power-up settle
      tick(3);
      check_output("rst_state", 64'(state), 64'd0);
      check_output("rst_lock",  64'(lock),  64'd0);
      check_output("rst_count", 64'(count), 64'd0);
      rst_n = 1'b1;
      tick(5);
      locked = 1'b1;
      tick(16);
      check_output("settle_lock_low", 64'(lock),  64'd0);
      check_output("settle_state",    64'(state), 64'd1);
      tick(1);
      check_output("settle_lock_high", 64'(lock),  64'd1);
      check_output("settle_halted",    64'(state), 64'd2);
      check_output("settle_count",     64'(count), 64'd0);

      // Free run with DIV=4, then halt
      div = 32'd4; run = 1'b1;
      tick(42);
      check_output("run_count10", 64'(count), 64'd10);
      check_output("run_state",   64'(state), 64'd3);
      halt = 1'b1;
      tick(1);
      check_output("halt_state", 64'(state), 64'd2);
      tick(10);
      check_output("halt_count", 64'(count), 64'd10);
      halt = 1'b0;
      tick(3);
      check_output("run_level_no_restart", 64'(state), 64'd2);
      run = 1'b0;
      tick(1);

      // Single steps, then step and run together
      for (int i = 0; i < 3; i++) begin
         step = 1'b1; tick(1);
         step = 1'b0; tick(4);
      end
      check_output("step_count3", 64'(count), 64'd13);
      step = 1'b1; run = 1'b1;
      tick(1);
      check_output("step_run_state", 64'(state),   64'd4);
      check_output("step_run_pulse", 64'(step_en), 64'd1);
      step = 1'b0;
      tick(2);
      check_output("step_run_halted", 64'(state), 64'd2);
      check_output("step_run_count",  64'(count), 64'd14);
      run = 1'b0;
      tick(1);

      // Breakpoint at 0x0010 with DIV=2
      div = 32'd2; bp_en = 1'b1; bp_pc = 16'h0010; pc = 16'h000C; run = 1'b1;
      tick(7);
      pc = 16'h0010;
      tick(2);
      check_output("bp_state", 64'(state),  64'd5);
      check_output("bp_hit",   64'(bp_hit), 64'd1);
      check_output("bp_count", 64'(count),  64'd17);
      step = 1'b1;
      tick(1);
      check_output("bp_step_state", 64'(state),   64'd4);
      check_output("bp_step_pulse", 64'(step_en), 64'd1);
      step = 1'b0;
      tick(1);
      check_output("bp_step_halted", 64'(state), 64'd2);
      run = 1'b0; tick(1);
      pc = 16'h000E; run = 1'b1;
      tick(3);
      pc = 16'h0010;
      tick(2);
      check_output("bp_again_state", 64'(state), 64'd5);
      run = 1'b0; tick(1);
      run = 1'b1;
      tick(3);
      check_output("bp_resume_state", 64'(state),   64'd3);
      check_output("bp_resume_pulse", 64'(step_en), 64'd1);
      tick(2);
      check_output("bp_retrap_state", 64'(state), 64'd5);
      run = 1'b0; bp_en = 1'b0;
      tick(1);

      // DIV=0 continuous, then shrink DIV mid-count
      div = 32'd0; run = 1'b1;
      tick(2);
      check_output("div0_first", 64'(step_en), 64'd1);
      tick(3);
      check_output("div0_cont", 64'(step_en), 64'd1);
      run = 1'b0;
      tick(2);
      div = 32'd100; run = 1'b1;
      tick(51);
      check_output("div100_idle", 64'(step_en), 64'd0);
      div = 32'd3;
      tick(1);
      check_output("div_shrink_pulse", 64'(step_en), 64'd1);
      tick(3);
      check_output("div3_next_pulse", 64'(step_en), 64'd1);

      // Lock loss, relock, then async reset mid-step
      locked = 1'b0;
      tick(1);
      check_output("lockloss_state", 64'(state),   64'd0);
      check_output("lockloss_lock",  64'(lock),    64'd0);
      check_output("lockloss_pulse", 64'(step_en), 64'd0);
      locked = 1'b1;
      tick(17);
      check_output("relock_state", 64'(state), 64'd3);
      check_output("relock_lock",  64'(lock),  64'd1);
      run = 1'b0;
      tick(1);
      step = 1'b1;
      tick(1);
      check_output("prereset_step", 64'(state), 64'd4);
      rst_n = 1'b0;
      #1;
      check_output("areset_state", 64'(state),   64'd0);
      check_output("areset_lock",  64'(lock),    64'd0);
      check_output("areset_pulse", 64'(step_en), 64'd0);
      check_output("areset_hit",   64'(bp_hit),  64'd0);
      check_output("areset_count", 64'(count),   64'd0);
      step = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(3);
      check_output("post_reset_settle", 64'(state), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
